// File: rtl/gate_chk_pkg.sv
// Shared types and constants for the gate sweep checker: FSM state encoding,
// settle counter width and the truth tables of the common 2-input gates.
package gate_chk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int SETTLE_W = 4;

    localparam logic [3:0] NAND2_TRUTH = 4'b0111;
    localparam logic [3:0] AND2_TRUTH  = 4'b1000;
    localparam logic [3:0] OR2_TRUTH   = 4'b1110;
    localparam logic [3:0] XOR2_TRUTH  = 4'b0110;

endpackage

// File: rtl/gate_chk_vec_gen.sv
// Vector generator for the gate sweep: ascending input vector plus settle
// counter, with a sample strobe at the end of each vector window.
module gate_chk_vec_gen
    import gate_chk_pkg::*;
#(
    parameter int N_IN   = 2,
    parameter int SETTLE = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            run,
    output logic [N_IN-1:0] dut_in,
    output logic            sample,
    output logic            last
);

    localparam logic [SETTLE_W-1:0] SETTLE_C = SETTLE_W'(SETTLE);

    logic [N_IN-1:0]     vec_q, vec_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;

    // The vector wraps to 0 after the last sample, so dut_in rests at 0.
    always_comb begin
        vec_d    = vec_q;
        settle_d = settle_q;
        if (clear) begin
            vec_d    = '0;
            settle_d = '0;
        end else if (run) begin
            if (settle_q == SETTLE_C) begin
                settle_d = '0;
                vec_d    = vec_q + 1'b1;
            end else begin
                settle_d = settle_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vec_q    <= '0;
            settle_q <= '0;
        end else begin
            vec_q    <= vec_d;
            settle_q <= settle_d;
        end
    end

    assign dut_in = vec_q;
    assign sample = run && (settle_q == SETTLE_C);
    assign last   = &vec_q;

endmodule

// File: rtl/gate_sweep_checker.sv
// Self-checking sweep engine for an N_IN-input gate against truth table TRUTH.
// Optional GATE_CHK_DISPLAY_EN adds simulation-only per-sample/summary prints.
//
// state | meaning
// IDLE  | waiting for start; results of last sweep held
// DRIVE | stepping vectors, sampling dut_out at end of each window
// DONE  | one-cycle done pulse, pass flag latched
module gate_sweep_checker
    import gate_chk_pkg::*;
#(
    parameter int                     N_IN   = 2,
    parameter int                     SETTLE = 1,
    parameter logic [(1<<N_IN)-1:0]   TRUTH  = NAND2_TRUTH
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic [N_IN-1:0] dut_in,
    input  logic            dut_out,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_cnt,
    output logic [N_IN-1:0] first_fail
);

    state_e            state_q, state_d;
    logic              pass_q, pass_d;
    logic [N_IN:0]     err_q, err_d;
    logic [N_IN-1:0]   ff_q, ff_d;

    logic              clear, run, sample, last;
    logic [N_IN-1:0]   vec;
    logic              exp_bit, mismatch;

    gate_chk_vec_gen #(
        .N_IN   (N_IN),
        .SETTLE (SETTLE)
    ) u_vec_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (clear),
        .run    (run),
        .dut_in (vec),
        .sample (sample),
        .last   (last)
    );

    assign exp_bit  = TRUTH[vec];
    // Case equality so an X/Z gate output is scored as a mismatch in simulation.
    assign mismatch = (dut_out === exp_bit) ? 1'b0 : 1'b1;

    always_comb begin
        state_d = state_q;
        pass_d  = pass_q;
        err_d   = err_q;
        ff_d    = ff_q;
        clear   = 1'b0;
        run     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = DRIVE;
                    clear   = 1'b1;
                    pass_d  = 1'b0;
                    err_d   = '0;
                    ff_d    = '0;
                end
            end
            DRIVE: begin
                run = 1'b1;
                if (sample) begin
                    if (mismatch) begin
                        err_d = err_q + 1'b1;
                        if (err_q == '0) begin
                            ff_d = vec;
                        end
                    end
                    if (last) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                pass_d  = (err_q == '0);
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pass_q  <= 1'b0;
            err_q   <= '0;
            ff_q    <= '0;
        end else begin
            state_q <= state_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            ff_q    <= ff_d;
        end
    end

    assign dut_in     = vec;
    assign busy       = (state_q == DRIVE);
    assign done       = (state_q == DONE);
    assign pass       = pass_q;
    assign err_cnt    = err_q;
    assign first_fail = ff_q;

`ifdef GATE_CHK_DISPLAY_EN
    always @(posedge clk) begin
        if (rst_n && sample) begin
            $display("vec=%b F=%b exp=%b", vec, dut_out, exp_bit);
        end
        if (rst_n && state_q == DONE) begin
            if (err_q == '0) $display("PASS");
            else             $display("FAIL errs=%0d", err_q);
        end
    end
`endif

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Directed and randomized checks of gate_sweep_checker against a truth-table
// reference model (error count = differing table bits, first fail = lowest).
module tb_gate_sweep_checker;

    localparam logic [3:0] NAND2_T = 4'b0111;
    localparam logic [3:0] XOR2_T  = 4'b0110;

    logic       clk;
    logic       rst_n;
    logic       start0, start1;
    logic [1:0] dut_in0, dut_in1;
    logic       dut_out0, dut_out1;
    logic       busy0, busy1, done0, done1, pass0, pass1;
    logic [2:0] err0, err1;
    logic [1:0] ff0, ff1;
    logic [3:0] gt0, gt1;

    int total = 0;
    int bad   = 0;

    assign dut_out0 = gt0[dut_in0];
    assign dut_out1 = gt1[dut_in1];

    gate_sweep_checker #(.N_IN(2), .SETTLE(1), .TRUTH(NAND2_T)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .dut_in(dut_in0),
        .dut_out(dut_out0), .busy(busy0), .done(done0), .pass(pass0),
        .err_cnt(err0), .first_fail(ff0)
    );

    gate_sweep_checker #(.N_IN(2), .SETTLE(0), .TRUTH(XOR2_T)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .dut_in(dut_in1),
        .dut_out(dut_out1), .busy(busy1), .done(done1), .pass(pass1),
        .err_cnt(err1), .first_fail(ff1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One sweep on u_dut0 (SETTLE=1, NAND2 table) with gate table tt.
    // extra_at: cycle with an extra start pulse; rst_at: cycle with rst_n low.
    task automatic sweep0(input logic [3:0] tt, input int extra_at, input int rst_at);
        int n_err;
        int ff_exp;
        n_err  = 0;
        ff_exp = 0;
        for (int k = 3; k >= 0; k--) begin
            if (tt[k] != NAND2_T[k]) begin
                n_err++;
                ff_exp = k;
            end
        end
        gt0 = tt;
        @(posedge clk); #1 start0 = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            start0 = (c == extra_at);
            rst_n  = (c != rst_at);
            @(negedge clk);
            if (rst_at != 0 && c == rst_at + 1) begin
                chk("rst_dut_in", dut_in0, 0);
                chk("rst_busy", busy0, 0);
                chk("rst_done", done0, 0);
                chk("rst_pass", pass0, 0);
                chk("rst_err", err0, 0);
                chk("rst_ff", ff0, 0);
                break;
            end
            if (c <= 8) begin
                chk("busy", busy0, 1);
                chk("dut_in", dut_in0, (c - 1) / 2);
                chk("done_lo", done0, 0);
            end else if (c == 9) begin
                chk("done_hi", done0, 1);
                chk("busy_done", busy0, 0);
                chk("err_cnt", err0, n_err);
                if (n_err != 0) chk("first_fail", ff0, ff_exp);
            end else begin
                chk("pass", pass0, (n_err == 0));
                chk("done_after", done0, 0);
                chk("err_hold", err0, n_err);
            end
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
        gt0    = NAND2_T;
        gt1    = XOR2_T;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", busy0, 0);
        chk("reset_done", done0, 0);
        chk("reset_pass", pass0, 0);
        chk("reset_err", err0, 0);
        chk("reset_dut_in", dut_in0, 0);
        chk("reset_busy1", busy1, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        sweep0(NAND2_T, 0, 0);       // matching gate
        sweep0(4'b1111, 0, 0);       // stuck-at-1
        sweep0(4'b1000, 0, 0);       // AND2 against NAND2 table
        sweep0(4'b0111, 3, 0);       // stray start mid-sweep
        sweep0(4'b1000, 0, 4);       // reset in cycle 4
        sweep0(4'b0111, 0, 0);       // fresh sweep after reset

        for (int i = 0; i < 8; i++) begin
            sweep0(4'($urandom_range(0, 15)), 0, 0);
        end

        // pass/err hold in IDLE
        gt0 = 4'b0111;
        sweep0(gt0, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("pass_hold", pass0, 1);

        // SETTLE=0 instance with start held high; one mismatch at vector 2
        gt1 = XOR2_T ^ 4'b0100;
        @(posedge clk); #1 start1 = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (c <= 4) begin
                chk("s0_busy", busy1, 1);
                chk("s0_dut_in", dut_in1, c - 1);
            end else if (c == 5) begin
                chk("s0_done", done1, 1);
                chk("s0_err", err1, 1);
                chk("s0_ff", ff1, 2);
            end else if (c == 6) begin
                chk("s0_idle_busy", busy1, 0);
                chk("s0_idle_done", done1, 0);
                chk("s0_pass", pass1, 0);
                chk("s0_err_hold", err1, 1);
            end else begin
                chk("s0_restart_busy", busy1, 1);
                chk("s0_restart_dut_in", dut_in1, 0);
                chk("s0_restart_err", err1, 0);
                chk("s0_restart_ff", ff1, 0);
            end
        end
        start1 = 1'b0;
        gt1 = XOR2_T;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("s0_second_pass", pass1, 1);
        chk("s0_second_err", err1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
